game_ctrl: RTL

Top-level game sequencer for the maze design. It consumes debounced key events and the current level's wall map, moves the player subject to walls and bounds, and handles level-up and game-clear transitions. It gates the stopwatch timer and requests one VGA redraw per position change, holding off further input until the redraw completes.

---
 rtl/game_ctrl_pkg.sv | 26 ++
 rtl/game_ctrl_maze_move_check.sv | 73 +++++++
 rtl/game_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the maze game sequencer.
//   ROW, COLUME      : default maze dimensions in cells
//   PosXW, PosYW     : widths of the player X/Y coordinates
//   state_e          : sequencer state encoding (also driven on o_State)
//   DirUp..DirRight  : bit positions inside the one-hot direction vector
package game_ctrl_pkg;

  localparam int unsigned ROW    = 30;
  localparam int unsigned COLUME = 40;

  localparam int unsigned PosXW = 7;
  localparam int unsigned PosYW = 6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StDraw  = 2'd2,
    StClear = 2'd3
  } state_e;

  localparam int unsigned DirUp    = 0;  // Y-1
  localparam int unsigned DirDown  = 1;  // Y+1
  localparam int unsigned DirLeft  = 2;  // X-1
  localparam int unsigned DirRight = 3;  // X+1

endpackage

// File: rtl/game_ctrl_maze_move_check.sv
// Combinational move legality check for one key event.
//   i_X, i_Y      : current player cell
//   i_Direction   : one-hot direction (up, down, left, right)
//   i_Map         : wall map, bit Y*COLUME+X, 1 = wall
//   o_TargetX/Y   : cell the move would land on (current cell if not one-hot)
//   o_fValid      : direction is one-hot, target is inside the grid and not a wall
//   o_fGoal       : move is valid and lands on the goal cell
module maze_move_check #(
  parameter int unsigned ROW    = game_ctrl_pkg::ROW,
  parameter int unsigned COLUME = game_ctrl_pkg::COLUME,
  parameter int unsigned GOAL_X = COLUME - 2,
  parameter int unsigned GOAL_Y = ROW - 2
) (
  input  logic [6:0]            i_X,
  input  logic [5:0]            i_Y,
  input  logic [3:0]            i_Direction,
  input  logic [ROW*COLUME-1:0] i_Map,
  output logic [6:0]            o_TargetX,
  output logic [5:0]            o_TargetY,
  output logic                  o_fValid,
  output logic                  o_fGoal
);

  import game_ctrl_pkg::*;

  localparam int unsigned CellW = $clog2(ROW * COLUME);

  logic             one_hot;
  logic             in_bounds;
  logic             wall;
  logic [CellW-1:0] cell_idx;

  always_comb begin
    one_hot   = $onehot(i_Direction);
    o_TargetX = i_X;
    o_TargetY = i_Y;
    in_bounds = 1'b0;
    if (one_hot) begin
      unique case (1'b1)
        i_Direction[DirUp]: begin
          in_bounds = (i_Y != '0);
          o_TargetY = i_Y - 6'd1;
        end
        i_Direction[DirDown]: begin
          in_bounds = (32'(i_Y) < ROW - 1);
          o_TargetY = i_Y + 6'd1;
        end
        i_Direction[DirLeft]: begin
          in_bounds = (i_X != '0);
          o_TargetX = i_X - 7'd1;
        end
        i_Direction[DirRight]: begin
          in_bounds = (32'(i_X) < COLUME - 1);
          o_TargetX = i_X + 7'd1;
        end
        default: in_bounds = 1'b0;
      endcase
    end
  end

  // Out-of-grid targets never address the map, so the index stays below ROW*COLUME.
  always_comb begin
    cell_idx = '0;
    if (in_bounds) begin
      cell_idx = CellW'(32'(o_TargetY) * COLUME + 32'(o_TargetX));
    end
    wall = i_Map[cell_idx];
  end

  assign o_fValid = one_hot & in_bounds & ~wall;
  assign o_fGoal  = o_fValid && (32'(o_TargetX) == GOAL_X) && (32'(o_TargetY) == GOAL_Y);

endmodule

// File: rtl/game_ctrl.sv
// Top-level maze game sequencer.
//   i_Clk, i_Rst     : clock, synchronous active-high reset
//   i_Direction      : one-hot direction sampled with i_fKey
//   i_fKey           : one-cycle key-event strobe
//   i_Map            : wall map of the current level (bit Y*COLUME+X, 1 = wall)
//   i_fDrawDone      : one-cycle strobe, renderer finished the frame
//   o_State          : IDLE=0, PLAY=1, DRAW=2, CLEAR=3
//   o_Level          : current level index
//   o_PlayerPos_X/Y  : player cell
//   o_fRunning       : stopwatch enable (PLAY or DRAW)
//   o_fUpdate        : one-cycle redraw request per position change
//   o_fLevelUP       : one-cycle pulse on level advance
// Every output comes straight from a register.
module game_ctrl #(
  parameter int unsigned ROW          = game_ctrl_pkg::ROW,
  parameter int unsigned COLUME       = game_ctrl_pkg::COLUME,
  parameter int unsigned START_X      = 1,
  parameter int unsigned START_Y      = 1,
  parameter int unsigned GOAL_X       = COLUME - 2,
  parameter int unsigned GOAL_Y       = ROW - 2,
  parameter int unsigned MAX_LEVEL    = 4,
  parameter int unsigned DRAW_TIMEOUT = 1000000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [3:0]            i_Direction,
  input  logic                  i_fKey,
  input  logic [ROW*COLUME-1:0] i_Map,
  input  logic                  i_fDrawDone,
  output logic [1:0]            o_State,
  output logic [1:0]            o_Level,
  output logic [6:0]            o_PlayerPos_X,
  output logic [5:0]            o_PlayerPos_Y,
  output logic                  o_fRunning,
  output logic                  o_fUpdate,
  output logic                  o_fLevelUP
);

  import game_ctrl_pkg::*;

  localparam int unsigned CntW = (DRAW_TIMEOUT > 1) ? $clog2(DRAW_TIMEOUT) : 1;

  localparam logic [6:0]      StartX    = 7'(START_X);
  localparam logic [5:0]      StartY    = 6'(START_Y);
  localparam logic [1:0]      LastLevel = 2'(MAX_LEVEL - 1);
  localparam logic [CntW-1:0] CntLast   = CntW'(DRAW_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [1:0]      level_q, level_d;
  logic [6:0]      x_q, x_d;
  logic [5:0]      y_q, y_d;
  logic            running_q, running_d;
  logic            update_q, update_d;
  logic            level_up_q, level_up_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [6:0] target_x;
  logic [5:0] target_y;
  logic       move_valid;
  logic       move_goal;

  maze_move_check #(
    .ROW    (ROW),
    .COLUME (COLUME),
    .GOAL_X (GOAL_X),
    .GOAL_Y (GOAL_Y)
  ) u_move_check (
    .i_X         (x_q),
    .i_Y         (y_q),
    .i_Direction (i_Direction),
    .i_Map       (i_Map),
    .o_TargetX   (target_x),
    .o_TargetY   (target_y),
    .o_fValid    (move_valid),
    .o_fGoal     (move_goal)
  );

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    update_d   = 1'b0;
    level_up_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_fKey) begin
          x_d      = StartX;
          y_d      = StartY;
          update_d = 1'b1;
          cnt_d    = '0;
          state_d  = StDraw;
        end
      end

      StPlay: begin
        if (i_fKey && move_valid) begin
          update_d = 1'b1;
          cnt_d    = '0;
          if (move_goal && (level_q < LastLevel)) begin
            level_d    = level_q + 2'd1;
            x_d        = StartX;
            y_d        = StartY;
            level_up_d = 1'b1;
            state_d    = StDraw;
          end else if (move_goal) begin
            // Last level finished: show the final cell and freeze the timer.
            x_d     = target_x;
            y_d     = target_y;
            state_d = StClear;
          end else begin
            x_d     = target_x;
            y_d     = target_y;
            state_d = StDraw;
          end
        end
      end

      StDraw: begin
        // Keys are dropped here; the renderer or the timeout releases PLAY.
        if (i_fDrawDone || (cnt_q == CntLast)) begin
          cnt_d   = '0;
          state_d = StPlay;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StClear: begin
        if (i_fKey) begin
          level_d = '0;
          x_d     = StartX;
          y_d     = StartY;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    running_d = (state_d == StPlay) || (state_d == StDraw);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= StIdle;
      level_q    <= '0;
      x_q        <= StartX;
      y_q        <= StartY;
      running_q  <= 1'b0;
      update_q   <= 1'b0;
      level_up_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      x_q        <= x_d;
      y_q        <= y_d;
      running_q  <= running_d;
      update_q   <= update_d;
      level_up_q <= level_up_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_State       = state_q;
  assign o_Level       = level_q;
  assign o_PlayerPos_X = x_q;
  assign o_PlayerPos_Y = y_q;
  assign o_fRunning    = running_q;
  assign o_fUpdate     = update_q;
  assign o_fLevelUP    = level_up_q;

endmodule
